sad_min_search: RTL and testbench

//  Downstream consumer of the previous-frame buffer. Each valid beat carries one 8-pixel current-block row
//  and 16 horizontally shifted 8-pixel reference rows (candidates 0..15).

---
 rtl/me_pkg.sv | 22 ++
 rtl/sad_row_unit.sv | 32 +++
 rtl/sad_min_search.sv | 190 +++++++++++++++++++
 tb/tb_sad_min_search.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and width helper for the motion-estimation SAD search.
package me_pkg;

  localparam int PIX_W       = 8;
  localparam int PIX_PER_ROW = 8;
  localparam int NUM_CAND    = 16;
  localparam int ZERO_IDX    = 7;
  localparam int ROW_W       = PIX_W * PIX_PER_ROW;
  localparam int ROW_SAD_W   = 11;
  localparam int GRP_SIZE    = 4;

  typedef enum logic {
    ACCUM  = 1'b0,
    SEARCH = 1'b1
  } me_state_e;

  // Bits needed to hold the worst-case SAD of a block of 'rows' rows.
  function automatic int sad_width(input int rows);
    return $clog2(rows * PIX_PER_ROW * ((1 << PIX_W) - 1) + 1);
  endfunction

endpackage

// File: rtl/sad_row_unit.sv
// One candidate's row SAD: 8 absolute differences, adder tree, output register.
module sad_row_unit
  import me_pkg::*;
(
  input  logic                 clk,
  input  logic [ROW_W-1:0]     cur_row,
  input  logic [ROW_W-1:0]     pre_row,
  output logic [ROW_SAD_W-1:0] row_sad_p1
);

  logic [ROW_SAD_W-1:0] row_sum;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Sum of absolute pixel differences across the row.
  always_comb begin
    row_sum = '0;
    for (int p = 0; p < PIX_PER_ROW; p++) begin
      row_sum = row_sum + ROW_SAD_W'(abs_diff(cur_row[ROW_W-1-PIX_W*p -: PIX_W],
                                              pre_row[ROW_W-1-PIX_W*p -: PIX_W]));
    end
  end

  // Stage 1 -> 2 boundary: register the row SAD (data only, no reset).
  always_ff @(posedge clk) begin
    row_sad_p1 <= row_sum;
  end

endmodule

// File: rtl/sad_min_search.sv
// Per-block SAD accumulation over 16 candidates followed by a 4-cycle minimum search.
// Optional build macro ME_ZERO_BIAS_EN: bias candidate 7 (zero motion) by ZBIAS in the compare.
module sad_min_search
  import me_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int SAD_W = 15,
  parameter int ZBIAS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [ROW_W-1:0]          cur_row,
  input  logic [NUM_CAND*ROW_W-1:0] pre_rows,
  input  logic                      frame_end,
  output logic                      result_valid,
  output logic signed [4:0]         best_mv,
  output logic [SAD_W-1:0]          best_sad,
  output logic                      overrun
);

`ifdef ME_ZERO_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(ROWS);

  logic [CNT_W-1:0]     row_cnt;
  logic                 fe_q;
  logic                 fe_rise;
  logic                 vld_p1;
  logic                 last_p1;
  logic [ROW_SAD_W-1:0] row_sad_p1 [NUM_CAND];
  logic [SAD_W-1:0]     acc        [NUM_CAND];
  logic [SAD_W-1:0]     bank       [NUM_CAND];
  me_state_e            state_q, state_d;
  logic [1:0]           grp_q, grp_d;
  logic                 bank_wr, busy, bank_take;
  logic [3:0]           best_idx_q, run_idx, c_idx;
  logic [SAD_W-1:0]     best_cmp_q, run_cmp, c_val;

  // Compare value: candidate 7 may get a floor-clamped zero-motion discount.
  function automatic logic [SAD_W-1:0] cmp_val(input logic [SAD_W-1:0] raw,
                                               input logic [3:0] idx);
    if (BIAS_EN && idx == 4'(ZERO_IDX))
      return (raw > SAD_W'(ZBIAS)) ? raw - SAD_W'(ZBIAS) : '0;
    return raw;
  endfunction

  assign fe_rise   = frame_end & ~fe_q;
  assign bank_wr   = vld_p1 & last_p1;
  // The search is still using the bank unless it is on its final group this cycle.
  assign busy      = (state_q == SEARCH) && (grp_q != 2'd3);
  assign bank_take = bank_wr & ~busy;

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_row
    sad_row_unit u_row (
      .clk        (clk),
      .cur_row    (cur_row),
      .pre_row    (pre_rows[ROW_W*k +: ROW_W]),
      .row_sad_p1 (row_sad_p1[k])
    );
  end

  // Stage 1: row counting, last-row flag and frame-end edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      fe_q <= frame_end;
      if (fe_rise) begin
        row_cnt <= '0;
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end else if (in_valid) begin
        vld_p1  <= 1'b1;
        last_p1 <= (row_cnt == CNT_W'(ROWS - 1));
        row_cnt <= (row_cnt == CNT_W'(ROWS - 1)) ? '0 : row_cnt + CNT_W'(1);
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  // Stage 2: accumulate, or move the finished block into the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      for (int k = 0; k < NUM_CAND; k++) begin
        acc[k]  <= '0;
        bank[k] <= '0;
      end
    end else begin
      if (bank_wr && busy) overrun <= 1'b1;
      for (int k = 0; k < NUM_CAND; k++) begin
        if (bank_wr) begin
          acc[k] <= '0;
          if (!busy) bank[k] <= acc[k] + SAD_W'(row_sad_p1[k]);
        end else if (fe_rise) begin
          acc[k] <= '0;
        end else if (vld_p1) begin
          acc[k] <= acc[k] + SAD_W'(row_sad_p1[k]);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      grp_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  // FSM next state: a new bank starts a search, four groups finish it.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    case (state_q)
      ACCUM: begin
        if (bank_take) begin
          state_d = SEARCH;
          grp_d   = 2'd0;
        end
      end
      SEARCH: begin
        if (grp_q == 2'd3) begin
          state_d = bank_take ? SEARCH : ACCUM;
          grp_d   = 2'd0;
        end else begin
          grp_d   = grp_q + 2'd1;
        end
      end
      default: begin
        state_d = ACCUM;
        grp_d   = 2'd0;
      end
    endcase
  end

  // Compare the current group of four against the running best; lower index wins ties.
  always_comb begin
    run_idx = best_idx_q;
    run_cmp = best_cmp_q;
    c_idx   = '0;
    c_val   = '0;
    for (int j = 0; j < GRP_SIZE; j++) begin
      c_idx = {grp_q, 2'(j)};
      c_val = cmp_val(bank[c_idx], c_idx);
      if (grp_q == 2'd0 && j == 0) begin
        run_idx = c_idx;
        run_cmp = c_val;
      end else if (c_val < run_cmp) begin
        run_idx = c_idx;
        run_cmp = c_val;
      end
    end
  end

  // Stage 3: running-best registers and the result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx_q   <= '0;
      best_cmp_q   <= '0;
      result_valid <= 1'b0;
      best_mv      <= '0;
      best_sad     <= '0;
    end else begin
      result_valid <= 1'b0;
      if (state_q == SEARCH) begin
        best_idx_q <= run_idx;
        best_cmp_q <= run_cmp;
        if (grp_q == 2'd3) begin
          result_valid <= 1'b1;
          best_mv      <= $signed({1'b0, run_idx}) - 5'sd7;
          best_sad     <= bank[run_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search (ROWS=8 main instance, ROWS=4 instance for back-to-back).
module tb_sad_min_search;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   cur_row = '0;
  logic [1023:0] pre_rows = '0;
  logic          frame_end = 1'b0;

  logic               rv, ovr, rv4, ovr4;
  logic signed [4:0]  mv, mv4;
  logic [14:0]        sad, sad4;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int last_edge = 0;
  int first_last = 0;

  int                q_cyc[$];
  logic signed [4:0] q_mv[$];
  logic [14:0]       q_sad[$];
  int                q4_cyc[$];
  logic signed [4:0] q4_mv[$];
  logic [14:0]       q4_sad[$];

  sad_min_search #(.ROWS(8), .SAD_W(15), .ZBIAS(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cur_row(cur_row), .pre_rows(pre_rows),
    .frame_end(frame_end), .result_valid(rv), .best_mv(mv), .best_sad(sad), .overrun(ovr)
  );

  sad_min_search #(.ROWS(4), .SAD_W(15), .ZBIAS(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cur_row(cur_row), .pre_rows(pre_rows),
    .frame_end(frame_end), .result_valid(rv4), .best_mv(mv4), .best_sad(sad4), .overrun(ovr4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rv) begin
      q_cyc.push_back(cyc); q_mv.push_back(mv); q_sad.push_back(sad);
    end
    if (rv4) begin
      q4_cyc.push_back(cyc); q4_mv.push_back(mv4); q4_sad.push_back(sad4);
    end
  end

  function automatic logic [1023:0] set_cand(input logic [1023:0] p, input int k,
                                             input logic [63:0] row);
    logic [1023:0] r;
    r = p;
    r[64*k +: 64] = row;
    return r;
  endfunction

  // Candidate 'k' equals cur (all 0x10), all others differ by 1 per pixel.
  function automatic logic [1023:0] one_match(input int k);
    return set_cand({128{8'h11}}, k, {8{8'h10}});
  endfunction

  task automatic beat(input logic [63:0] c, input logic [1023:0] p);
    in_valid = 1'b1; cur_row = c; pre_rows = p;
    @(posedge clk); #1;
    last_edge = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_cyc.delete(); q_mv.delete(); q_sad.delete();
    q4_cyc.delete(); q4_mv.delete(); q4_sad.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (rv !== 1'b0) begin err++; $display("FAIL reset_rv: got %b expected 0", rv); end
    vec++; if (mv !== 5'sd0) begin err++; $display("FAIL reset_mv: got %0d expected 0", mv); end
    vec++; if (sad !== 15'd0) begin err++; $display("FAIL reset_sad: got %0d expected 0", sad); end
    vec++; if (ovr !== 1'b0) begin err++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_uniform();
    do_reset();
    for (int r = 0; r < 8; r++) beat({8{8'h01}}, '0);
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL uni_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - last_edge !== 5) begin err++; $display("FAIL uni_latency: got %0d expected 5", q_cyc[0] - last_edge); end
      vec++; if (q_mv[0] !== -5'sd7) begin err++; $display("FAIL uni_mv: got %0d expected -7", q_mv[0]); end
      vec++; if (q_sad[0] !== 15'd64) begin err++; $display("FAIL uni_sad: got %0d expected 64", q_sad[0]); end
    end
  endtask

  task automatic test_match12();
    do_reset();
    for (int r = 0; r < 8; r++) beat({8{8'h10}}, one_match(12));
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL m12_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_mv[0] !== 5'sd5) begin err++; $display("FAIL m12_mv: got %0d expected 5", q_mv[0]); end
      vec++; if (q_sad[0] !== 15'd0) begin err++; $display("FAIL m12_sad: got %0d expected 0", q_sad[0]); end
    end
    vec++; if (ovr !== 1'b0) begin err++; $display("FAIL m12_ovr: got %b expected 0", ovr); end
  endtask

  // Candidates 3 and 9 differ by 5 in one pixel per row (40 total); the rest by 16 per pixel.
  function automatic logic [1023:0] tie_rows();
    logic [1023:0] p;
    p = {128{8'h30}};
    p = set_cand(p, 3, {8'h25, {7{8'h20}}});
    p = set_cand(p, 9, {8'h25, {7{8'h20}}});
    return p;
  endfunction

  task automatic test_tie();
    do_reset();
    for (int r = 0; r < 8; r++) beat({8{8'h20}}, tie_rows());
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL tie_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_mv[0] !== -5'sd4) begin err++; $display("FAIL tie_mv: got %0d expected -4", q_mv[0]); end
      vec++; if (q_sad[0] !== 15'd40) begin err++; $display("FAIL tie_sad: got %0d expected 40", q_sad[0]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 4; r++) beat({8{8'h10}}, one_match(12));
    first_last = last_edge;
    for (int r = 0; r < 4; r++) beat({8{8'h10}}, one_match(3));
    idle(14);
    vec++; if (q4_cyc.size() !== 2) begin err++; $display("FAIL b2b_count: got %0d expected 2", q4_cyc.size()); end
    if (q4_cyc.size() >= 2) begin
      vec++; if (q4_cyc[0] - first_last !== 5) begin err++; $display("FAIL b2b_latency: got %0d expected 5", q4_cyc[0] - first_last); end
      vec++; if (q4_cyc[1] - q4_cyc[0] !== 4) begin err++; $display("FAIL b2b_spacing: got %0d expected 4", q4_cyc[1] - q4_cyc[0]); end
      vec++; if (q4_mv[0] !== 5'sd5) begin err++; $display("FAIL b2b_mv0: got %0d expected 5", q4_mv[0]); end
      vec++; if (q4_mv[1] !== -5'sd4) begin err++; $display("FAIL b2b_mv1: got %0d expected -4", q4_mv[1]); end
      vec++; if (q4_sad[1] !== 15'd0) begin err++; $display("FAIL b2b_sad1: got %0d expected 0", q4_sad[1]); end
    end
    vec++; if (ovr4 !== 1'b0) begin err++; $display("FAIL b2b_ovr: got %b expected 0", ovr4); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    for (int r = 0; r < 3; r++) beat({8{8'h10}}, one_match(12));
    rst = 1'b1;
    beat({8{8'h10}}, one_match(12));
    rst = 1'b0;
    for (int r = 0; r < 8; r++) beat({8{8'h20}}, tie_rows());
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL abort_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - last_edge !== 5) begin err++; $display("FAIL abort_latency: got %0d expected 5", q_cyc[0] - last_edge); end
      vec++; if (q_mv[0] !== -5'sd4) begin err++; $display("FAIL abort_mv: got %0d expected -4", q_mv[0]); end
      vec++; if (q_sad[0] !== 15'd40) begin err++; $display("FAIL abort_sad: got %0d expected 40", q_sad[0]); end
    end
  endtask

  task automatic test_frame_end();
    do_reset();
    for (int r = 0; r < 3; r++) beat({8{8'h10}}, {128{8'h55}});
    frame_end = 1'b1;
    beat({8{8'h10}}, {128{8'h55}});
    frame_end = 1'b0;
    for (int r = 0; r < 8; r++) beat({8{8'h10}}, one_match(12));
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL fe_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - last_edge !== 5) begin err++; $display("FAIL fe_latency: got %0d expected 5", q_cyc[0] - last_edge); end
      vec++; if (q_mv[0] !== 5'sd5) begin err++; $display("FAIL fe_mv: got %0d expected 5", q_mv[0]); end
      vec++; if (q_sad[0] !== 15'd0) begin err++; $display("FAIL fe_sad: got %0d expected 0", q_sad[0]); end
    end
  endtask

  // Row 0 makes bank[7]=30, bank[2]=20, others 100; the remaining rows match exactly.
  task automatic test_zero_bias();
    logic [1023:0] p;
    logic signed [4:0] exp_mv;
    logic [14:0] exp_sad;
`ifdef ME_ZERO_BIAS_EN
    exp_mv = 5'sd0;  exp_sad = 15'd30;
`else
    exp_mv = -5'sd5; exp_sad = 15'd20;
`endif
    do_reset();
    p = {128{8'h40}};
    for (int k = 0; k < 16; k++) p = set_cand(p, k, {8'hA4, {7{8'h40}}});
    p = set_cand(p, 7, {8'h5E, {7{8'h40}}});
    p = set_cand(p, 2, {8'h54, {7{8'h40}}});
    beat({8{8'h40}}, p);
    for (int r = 1; r < 8; r++) beat({8{8'h40}}, {128{8'h40}});
    idle(12);
    vec++; if (q_cyc.size() !== 1) begin err++; $display("FAIL zb_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_mv[0] !== exp_mv) begin err++; $display("FAIL zb_mv: got %0d expected %0d", q_mv[0], exp_mv); end
      vec++; if (q_sad[0] !== exp_sad) begin err++; $display("FAIL zb_sad: got %0d expected %0d", q_sad[0], exp_sad); end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_match12();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_frame_end();
    test_zero_bias();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
